// File: rtl/control_pipe_if.sv
// Control-pipe bus: IF/ID-side inputs and the ID/EX, EX/MEM, MEM/WB control outputs.
interface control_pipe_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 8
);
    logic [5:0]        opcode;
    logic [REG_AW-1:0] if_id_rs;
    logic [REG_AW-1:0] if_id_rt;
    logic              flush;
    logic [3:0]        ex_EX;
    logic [2:0]        ex_M;
    logic [1:0]        ex_WB;
    logic [REG_AW-1:0] ex_rt;
    logic [2:0]        mem_M;
    logic [1:0]        mem_WB;
    logic [1:0]        wb_WB;
    logic              stall;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    modport master (
        output opcode, if_id_rs, if_id_rt, flush,
        input  ex_EX, ex_M, ex_WB, ex_rt, mem_M, mem_WB, wb_WB, stall, illegal, illegal_cnt
    );

    modport slave (
        input  opcode, if_id_rs, if_id_rt, flush,
        output ex_EX, ex_M, ex_WB, ex_rt, mem_M, mem_WB, wb_WB, stall, illegal, illegal_cnt
    );
endinterface

// File: rtl/control_pipe.sv
// Pipelined control decoder: decodes opcode into EX/M/WB bundles, carries them to WB,
// and inserts load-use bubbles, branch flushes and illegal-opcode counting.
module control_pipe #(
    parameter int REG_AW    = 5,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 8
) (
    input logic          clk,
    input logic          rst_n,
    control_pipe_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_NOP   = 6'b100000;

    // Result layout: {EX[3:0], M[2:0], WB[1:0], illegal}
    function automatic logic [9:0] decode(input logic [5:0] op);
        case (op)
            OP_RTYPE: decode = 10'b1100_000_10_0;
            OP_LW:    decode = 10'b0001_010_11_0;
            OP_SW:    decode = 10'b0001_001_00_0;
            OP_BEQ:   decode = 10'b0010_100_00_0;
            OP_NOP:   decode = 10'b0000_000_00_0;
            default:  decode = 10'b0000_000_00_1;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    logic [9:0]        dec_d;
    logic              stall_d;

    logic [3:0]        ex_ex_p0_q;
    logic [2:0]        ex_m_p0_q;
    logic [1:0]        ex_wb_p0_q;
    logic [REG_AW-1:0] ex_rt_p0_q;
    logic              ill_p0_q;
    logic [2:0]        mem_m_p1_q;
    logic [1:0]        mem_wb_p1_q;
    logic [1:0]        wb_wb_p2_q;
    logic [CNT_W-1:0]  cnt_q;

    assign dec_d = decode(bus.opcode);

    // Load in ID/EX whose destination feeds the instruction in IF/ID; a flush overrides it.
    assign stall_d = HAZARD_EN && ex_m_p0_q[1] && !bus.flush &&
                     ((ex_rt_p0_q == bus.if_id_rs) || (ex_rt_p0_q == bus.if_id_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ex_p0_q  <= '0;
            ex_m_p0_q   <= '0;
            ex_wb_p0_q  <= '0;
            ex_rt_p0_q  <= '0;
            ill_p0_q    <= 1'b0;
            mem_m_p1_q  <= '0;
            mem_wb_p1_q <= '0;
            wb_wb_p2_q  <= '0;
            cnt_q       <= '0;
        end else begin
            // MEM/WB boundary always advances
            wb_wb_p2_q <= mem_wb_p1_q;
            if (bus.flush) begin
                ex_ex_p0_q  <= '0;
                ex_m_p0_q   <= '0;
                ex_wb_p0_q  <= '0;
                ex_rt_p0_q  <= '0;
                ill_p0_q    <= 1'b0;
                mem_m_p1_q  <= '0;
                mem_wb_p1_q <= '0;
            end else begin
                // EX/MEM boundary advances on both stall and normal cycles
                mem_m_p1_q  <= ex_m_p0_q;
                mem_wb_p1_q <= ex_wb_p0_q;
                if (stall_d) begin
                    ex_ex_p0_q <= '0;
                    ex_m_p0_q  <= '0;
                    ex_wb_p0_q <= '0;
                    ex_rt_p0_q <= '0;
                    ill_p0_q   <= 1'b0;
                end else begin
                    // ID/EX boundary: fresh decode
                    ex_ex_p0_q <= dec_d[9:6];
                    ex_m_p0_q  <= dec_d[5:3];
                    ex_wb_p0_q <= dec_d[2:1];
                    ex_rt_p0_q <= bus.if_id_rt;
                    ill_p0_q   <= dec_d[0];
                    if (dec_d[0]) begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
            end
        end
    end

    assign bus.ex_EX       = ex_ex_p0_q;
    assign bus.ex_M        = ex_m_p0_q;
    assign bus.ex_WB       = ex_wb_p0_q;
    assign bus.ex_rt       = ex_rt_p0_q;
    assign bus.mem_M       = mem_m_p1_q;
    assign bus.mem_WB      = mem_wb_p1_q;
    assign bus.wb_WB       = wb_wb_p2_q;
    assign bus.stall       = stall_d;
    assign bus.illegal     = ill_p0_q;
    assign bus.illegal_cnt = cnt_q;
endmodule
